// File: rtl/snn_pkg.sv
// Shared definitions for the SNN stage sequencer.
//   - one-hot state constants (bit index = position in the stage output)
//   - clock-gate domain bit indices
//   - frame / stage length constants
//   - cg_domains(): which gate domains a given state keeps awake
package snn_pkg;

  localparam int unsigned N_SAMP      = 72;
  localparam int unsigned N_KER       = 9;
  localparam int unsigned N_WGT       = 4;
  localparam int unsigned IMG_SAMP    = 36;  // samples per 6x6 image
  localparam int unsigned CONV_CYC    = 34;
  localparam int unsigned CONV_WIN    = 16;  // 4x4 window origins per image
  localparam int unsigned FMAP_SPLIT  = 18;
  localparam int unsigned Q1_CYC      = 16;
  localparam int unsigned Q2_CYC      = 4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_INPUT = 4'd1,
    S_CONV  = 4'd2,
    S_QUAN1 = 4'd3,
    S_POOL  = 4'd4,
    S_FC    = 4'd5,
    S_QUAN2 = 4'd6,
    S_DIST  = 4'd7,
    S_ACT   = 4'd8,
    S_OUT   = 4'd9
  } state_idx_e;

  localparam logic [9:0] ST_IDLE  = 10'b00_0000_0001;
  localparam logic [9:0] ST_INPUT = 10'b00_0000_0010;
  localparam logic [9:0] ST_CONV  = 10'b00_0000_0100;
  localparam logic [9:0] ST_QUAN1 = 10'b00_0000_1000;
  localparam logic [9:0] ST_POOL  = 10'b00_0001_0000;
  localparam logic [9:0] ST_FC    = 10'b00_0010_0000;
  localparam logic [9:0] ST_QUAN2 = 10'b00_0100_0000;
  localparam logic [9:0] ST_DIST  = 10'b00_1000_0000;
  localparam logic [9:0] ST_ACT   = 10'b01_0000_0000;
  localparam logic [9:0] ST_OUT   = 10'b10_0000_0000;

  localparam int unsigned CG_IN    = 0;
  localparam int unsigned CG_MAC   = 1;
  localparam int unsigned CG_FMAP  = 2;
  localparam int unsigned CG_QUANT = 3;
  localparam int unsigned CG_POOL  = 4;
  localparam int unsigned CG_FC    = 5;
  localparam int unsigned CG_OUT   = 6;

  // Gate domains that must be clocked while the FSM sits in state st.
  function automatic logic [6:0] cg_domains(input logic [9:0] st);
    logic [6:0] d;
    d           = '0;
    d[CG_IN]    = st[S_INPUT];
    d[CG_MAC]   = st[S_CONV];
    d[CG_FMAP]  = st[S_CONV] | st[S_QUAN1] | st[S_POOL] | st[S_FC] |
                  st[S_QUAN2] | st[S_DIST] | st[S_ACT];
    d[CG_QUANT] = st[S_QUAN1] | st[S_QUAN2];
    d[CG_POOL]  = st[S_POOL];
    d[CG_FC]    = st[S_FC];
    d[CG_OUT]   = st[S_OUT];
    return d;
  endfunction

endpackage

// File: rtl/snn_win_idx.sv
// Row/column index generator.
//   win4 = 0 : 6x6 raster (image write index), wraps 5,5 -> 0,0
//   win4 = 1 : 4x4 raster (conv window origin), wraps 3,3 -> 0,0
// Ports: clk, rst (sync, active-high), clr (force 0,0; wins over step),
//        step (advance one raster position), win4 (mode), row/col (flop Q).
module snn_win_idx (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       step,
  input  logic       win4,
  output logic [2:0] row,
  output logic [2:0] col
);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [2:0] lim;

  always_comb begin
    lim   = win4 ? 3'd3 : 3'd5;
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = 3'd0;
      col_d = 3'd0;
    end else if (step) begin
      if (col_q == lim) begin
        col_d = 3'd0;
        row_d = (row_q == lim) ? 3'd0 : row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= 3'd0;
      col_q <= 3'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/snn_stage_sched.sv
// Central sequencer for the SNN inference datapath.
// Counts input samples, walks the fixed stage schedule and drives the
// datapath strobes, indices, bank selects and clock-gate enables.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid           input sample strobe
//   stage[9:0]         one-hot state (also serves as the FSM debug view)
//   cnt[6:0]           stage-local counter
//   row, col [2:0]     image write index (INPUT) / window origin (CONV)
//   ker_we, wgt_we     kernel / weight shift strobes
//   img_bank           image select, fmap_bank conv result target
//   quan_div2          quantizer divisor select (0: 2295, 1: 510)
//   cg_en[6:0]         clock-gate enables (combinational)
//   out_valid          result-valid strobe, frame_err error pulse
// Handshake: in_valid has no ready. A sample is accepted on every edge where
// in_valid is high in IDLE (sample 0) or in INPUT before sample 71. In INPUT
// the flops show the index of the last accepted sample, so registered
// strobes line up with cnt/row/col. In_valid in CONV..OUT is an error.
module snn_stage_sched
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic [9:0] stage,
  output logic [6:0] cnt,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       ker_we,
  output logic       wgt_we,
  output logic       img_bank,
  output logic       fmap_bank,
  output logic       quan_div2,
  output logic [6:0] cg_en,
  output logic       out_valid,
  output logic       frame_err
);

  logic [9:0] state_q, state_d, state_nx;
  logic [6:0] cnt_q, cnt_d;
  logic ker_we_q, ker_we_d, wgt_we_q, wgt_we_d;
  logic img_bank_q, img_bank_d, fmap_bank_q, fmap_bank_d;
  logic quan_div2_q, quan_div2_d, out_valid_q, out_valid_d;
  logic frame_err_q, frame_err_d;
  logic win_clr, win_step, busy;

  assign busy = |(state_q & ~(ST_IDLE | ST_INPUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ker_we_d    = 1'b0;
    wgt_we_d    = 1'b0;
    img_bank_d  = 1'b0;
    fmap_bank_d = 1'b0;
    quan_div2_d = 1'b0;
    out_valid_d = 1'b0;
    frame_err_d = in_valid & busy;
    win_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d  = ST_INPUT;
          cnt_d    = 7'd0;
          ker_we_d = 1'b1;
          wgt_we_d = 1'b1;
        end
      end
      ST_INPUT: begin
        if (cnt_q == 7'(N_SAMP - 1)) begin
          state_d = ST_CONV;
          cnt_d   = 7'd0;
        end else if (in_valid) begin
          cnt_d      = cnt_q + 7'd1;
          ker_we_d   = (cnt_d < 7'(N_KER));
          wgt_we_d   = (cnt_d < 7'(N_WGT));
          img_bank_d = (cnt_d >= 7'(IMG_SAMP));
          win_step   = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          cnt_d       = 7'd0;
          frame_err_d = 1'b1;
        end
      end
      ST_CONV: begin
        if (cnt_q == 7'(CONV_CYC - 1)) begin
          state_d = ST_QUAN1;
          cnt_d   = 7'd0;
        end else begin
          cnt_d       = cnt_q + 7'd1;
          img_bank_d  = (cnt_d >= 7'(CONV_WIN));
          fmap_bank_d = (cnt_d >= 7'(FMAP_SPLIT));
          win_step    = 1'b1;
        end
      end
      ST_QUAN1: begin
        if (cnt_q == 7'(Q1_CYC - 1)) begin
          state_d = ST_POOL;
          cnt_d   = 7'd0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_POOL: begin
        // 2x2 pooling origins inside the 4x4 feature map: 0, 2, 8, 10.
        if (cnt_q == 7'd10) begin
          state_d = ST_FC;
          cnt_d   = 7'd0;
        end else if (cnt_q == 7'd0) begin
          cnt_d = 7'd2;
        end else if (cnt_q == 7'd2) begin
          cnt_d = 7'd8;
        end else begin
          cnt_d = 7'd10;
        end
      end
      ST_FC: begin
        state_d     = ST_QUAN2;
        cnt_d       = 7'd0;
        quan_div2_d = 1'b1;
      end
      ST_QUAN2: begin
        if (cnt_q == 7'(Q2_CYC - 1)) begin
          state_d = ST_DIST;
          cnt_d   = 7'd0;
        end else begin
          cnt_d       = cnt_q + 7'd1;
          quan_div2_d = 1'b1;
        end
      end
      ST_DIST: state_d = ST_ACT;
      ST_ACT:  state_d = ST_OUT;
      ST_OUT: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 7'd0;
      end
    endcase
  end

  // Index restarts at 0,0 on every stage entry and is held at 0,0 outside
  // INPUT/CONV.
  assign win_clr = (state_d != state_q) ||
                   !((state_d == ST_INPUT) || (state_d == ST_CONV));

  snn_win_idx u_win_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (win_clr),
    .step (win_step),
    .win4 (state_q == ST_CONV),
    .row  (row),
    .col  (col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 7'd0;
      ker_we_q    <= 1'b0;
      wgt_we_q    <= 1'b0;
      img_bank_q  <= 1'b0;
      fmap_bank_q <= 1'b0;
      quan_div2_q <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ker_we_q    <= ker_we_d;
      wgt_we_q    <= wgt_we_d;
      img_bank_q  <= img_bank_d;
      fmap_bank_q <= fmap_bank_d;
      quan_div2_q <= quan_div2_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Gate enables lead by one cycle: a domain wakes while the state that
  // needs it is still only the next state, giving the ICG latch set-up time.
  assign state_nx = rst ? ST_IDLE : state_d;
  assign cg_en    = cg_domains(state_q) | cg_domains(state_nx);

  assign stage     = state_q;
  assign cnt       = cnt_q;
  assign ker_we    = ker_we_q;
  assign wgt_we    = wgt_we_q;
  assign img_bank  = img_bank_q;
  assign fmap_bank = fmap_bank_q;
  assign quan_div2 = quan_div2_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_snn_stage_sched.sv
// Testbench for snn_stage_sched: randomized frames against a schedule-table
// reference model, with a per-cycle expected queue and an out_valid latency
// queue checked by a separate monitor.
module tb_snn_stage_sched;

  localparam int W = 37;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [9:0] stage;
  logic [6:0] cnt;
  logic [2:0] row, col;
  logic ker_we, wgt_we, img_bank, fmap_bank, quan_div2, out_valid, frame_err;
  logic [6:0] cg_en;

  snn_stage_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .stage     (stage),
    .cnt       (cnt),
    .row       (row),
    .col       (col),
    .ker_we    (ker_we),
    .wgt_we    (wgt_we),
    .img_bank  (img_bank),
    .fmap_bank (fmap_bank),
    .quan_div2 (quan_div2),
    .cg_en     (cg_en),
    .out_valid (out_valid),
    .frame_err (frame_err)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           ov_q[$];
  int           n_checks = 0;
  int           n_err    = 0;

  // ---------------- reference model ----------------
  // phase 0 idle, 1 input (m_idx = last accepted sample), 2 processing
  // (m_off = cycles since CONV entry; 62-cycle fixed schedule).
  int m_phase = 0;
  int m_idx   = 0;
  int m_off   = 0;
  bit m_ov    = 1'b0;
  bit m_fe    = 1'b0;
  int pool_cnt[4] = '{0, 2, 8, 10};

  // Stage index: 0 IDLE 1 INPUT 2 CONV 3 QUAN1 4 POOL 5 FC 6 QUAN2 7 DIST 8 ACT 9 OUT
  function automatic int stage_of(input int ph, input int off);
    if (ph == 0) return 0;
    if (ph == 1) return 1;
    if (off < 34) return 2;
    if (off < 50) return 3;
    if (off < 54) return 4;
    if (off == 54) return 5;
    if (off < 59) return 6;
    return 7 + (off - 59);
  endfunction

  function automatic logic [6:0] domains(input int s);
    logic [6:0] d;
    d    = '0;
    d[0] = (s == 1);
    d[1] = (s == 2);
    d[2] = (s >= 2) && (s <= 8);
    d[3] = (s == 3) || (s == 6);
    d[4] = (s == 4);
    d[5] = (s == 5);
    d[6] = (s == 9);
    return d;
  endfunction

  // {stage, cnt, row, col, ker, wgt, img, fmap, qdiv2, out_valid, frame_err}
  function automatic logic [29:0] observe();
    logic [9:0] st;
    int s, c, r, k;
    logic ker, wgt, img, fmap, qd;
    s = stage_of(m_phase, m_off);
    st = '0;
    st[s] = 1'b1;
    c = 0; r = 0; k = 0;
    ker = 0; wgt = 0; img = 0; fmap = 0; qd = 0;
    if (m_phase == 1) begin
      c = m_idx;
      r = (m_idx % 36) / 6;
      k = m_idx % 6;
      ker = (m_idx < 9);
      wgt = (m_idx < 4);
      img = (m_idx >= 36);
    end else if (m_phase == 2) begin
      case (s)
        2: begin
          c = m_off;
          r = (m_off % 16) / 4;
          k = m_off % 4;
          img = (m_off >= 16);
          fmap = (m_off >= 18);
        end
        3: c = m_off - 34;
        4: c = pool_cnt[m_off - 50];
        6: begin c = m_off - 55; qd = 1'b1; end
        default: c = 0;
      endcase
    end
    return {st, 7'(c), 3'(r), 3'(k), ker, wgt, img, fmap, qd, m_ov, m_fe};
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle's inputs, pushes the expectation for this cycle,
  // advances the model across the coming edge.
  task automatic cycle(input bit iv, input bit r);
    logic [29:0] o;
    int s0, s1;
    in_valid = iv;
    rst      = r;
    o  = observe();
    s0 = stage_of(m_phase, m_off);
    m_ov = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_phase = 0; m_idx = 0; m_off = 0;
      ov_q.delete();
    end else begin
      case (m_phase)
        0: if (iv) begin m_phase = 1; m_idx = 0; end
        1: begin
          if (m_idx == 71) begin
            m_phase = 2; m_off = 0;
          end else if (iv) begin
            m_idx++;
            if (m_idx == 71) ov_q.push_back(cyc + 64);
          end else begin
            m_fe = 1'b1; m_phase = 0; m_idx = 0;
          end
        end
        default: begin
          if (iv) m_fe = 1'b1;
          if (m_off == 61) begin
            m_phase = 0; m_off = 0; m_ov = 1'b1;
          end else begin
            m_off++;
          end
        end
      endcase
    end
    s1 = stage_of(m_phase, m_off);
    exp_q.push_back({o, domains(s0) | domains(s1)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  // drop_at: sample index after which in_valid drops (-1 none)
  // busy_pct: chance of a stray in_valid per processing cycle
  // rst_off: processing offset at which rst is asserted (-1 none)
  task automatic run_frame(input int drop_at, input int busy_pct, input int rst_off);
    int guard;
    bit iv, r;
    guard = 0;
    do begin
      iv = 1'b0;
      r  = 1'b0;
      case (m_phase)
        0: iv = 1'b1;
        1: iv = (m_idx != drop_at) && (m_idx != 71);
        default: begin
          iv = ($urandom_range(0, 99) < busy_pct);
          r  = (m_off == rst_off);
        end
      endcase
      cycle(iv, r);
      guard++;
    end while (m_phase != 0 && guard < 300);
    if (guard >= 300) begin
      n_checks++;
      n_err++;
      $display("FAIL frame_guard actual=%0d cycles required<300", guard);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    int t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stage",   16'(stage), 16'(e[36:27]));
      check("cnt",     16'(cnt), 16'(e[26:20]));
      check("row_col", 16'({row, col}), 16'(e[19:14]));
      check("strobes", 16'({ker_we, wgt_we, img_bank, fmap_bank, quan_div2, out_valid, frame_err}),
            16'(e[13:7]));
      check("cg_en",   16'(cg_en), 16'(e[6:0]));
    end
    if (out_valid === 1'b1) begin
      n_checks++;
      if (ov_q.size() == 0) begin
        n_err++;
        $display("FAIL ov_latency cyc=%0d actual=out_valid required=no result pending", cyc);
      end else begin
        t = ov_q.pop_front();
        if (t != cyc) begin
          n_err++;
          $display("FAIL ov_latency actual=cycle %0d required=cycle %0d", cyc, t);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    idle(2);
    run_frame(-1, 0, -1);           // clean frame
    idle(3);
    run_frame(40, 0, -1);           // short frame
    idle(3);
    run_frame(-1, 30, -1);          // stray in_valid while busy
    idle(2);
    run_frame(-1, 0, 51);           // reset inside POOL
    idle(2);
    run_frame(-1, 0, -1);
    idle(2);
    run_frame(-1, 0, -1);           // back-to-back frames
    run_frame(-1, 10, -1);
    idle(3);
    for (int i = 0; i < 5; i++) begin
      run_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : -1,
                int'($urandom_range(0, 20)), -1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);
    @(negedge clk);
    #1;
    n_checks++;
    if (ov_q.size() != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d results/%0d cycles pending required=0", ov_q.size(), exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
